// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, cycle-count defaults and the register-hazard rule for the
// hazard controller and its multiply/divide busy sequencer.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // A source must wait when its producer is younger than the consumer's need;
  // $0 is hard-wired and never waits.
  function automatic logic reg_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: D/E/M stage
// operand and destination information in, stall/enable controls out.
interface hazard_ctrl_if;

  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_Tuse_rs;
  logic [1:0]  D_Tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_writeReg_NUM;
  logic [1:0]  E_Tnew;
  logic [4:0]  M_writeReg_NUM;
  logic [1:0]  M_Tnew;
  logic        E_md_start;
  logic        E_md_is_div;

  logic        stall;
  logic        PC_en;
  logic        D_en;
  logic        E_flush;
  logic        md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
           E_writeReg_NUM, E_Tnew, M_writeReg_NUM, M_Tnew,
           E_md_start, E_md_is_div,
    input  stall, PC_en, D_en, E_flush, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
           E_writeReg_NUM, E_Tnew, M_writeReg_NUM, M_Tnew,
           E_md_start, E_md_is_div,
    output stall, PC_en, D_en, E_flush, md_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_seq.sv
// Multiply/divide occupancy sequencer: busy for MULT_CYCLES or DIV_CYCLES
// cycles counted from the issuing cycle; restarts while busy are ignored.
module md_busy_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic E_md_start,
  input  logic E_md_is_div,
  output logic md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e  state_q;
  logic [3:0] md_cnt_q;
  logic [3:0] load_val;

  assign load_val = E_md_is_div ? DIV_LOAD : MULT_LOAD;

  // The issuing cycle counts as busy before the state register catches up.
  assign md_busy = E_md_start || (state_q == BUSY);

  // NOTE: state is written with <= only, so every read in this block sees the
  // pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      md_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A one-cycle operation has a zero load and never leaves IDLE.
          if (E_md_start && (load_val != 4'd0)) begin
            state_q  <= BUSY;
            md_cnt_q <= load_val;
          end
        end
        BUSY: begin
          if (md_cnt_q == 4'd1) begin
            state_q  <= IDLE;
            md_cnt_q <= 4'd0;
          end else begin
            md_cnt_q <= md_cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data-hazard detection, HI/LO busy
// interlock, front-end enables and a saturating stalled-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  logic        hazard_rs;
  logic        hazard_rt;
  logic        md_busy;
  logic        md_stall;
  logic        stall;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  assign hazard_rs = reg_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_writeReg_NUM, bus.E_Tnew)
                  || reg_hazard(bus.D_rs, bus.D_Tuse_rs, bus.M_writeReg_NUM, bus.M_Tnew);
  assign hazard_rt = reg_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_writeReg_NUM, bus.E_Tnew)
                  || reg_hazard(bus.D_rt, bus.D_Tuse_rt, bus.M_writeReg_NUM, bus.M_Tnew);

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_seq (
    .clk         (clk),
    .reset       (reset),
    .E_md_start  (bus.E_md_start),
    .E_md_is_div (bus.E_md_is_div),
    .md_busy     (md_busy)
  );

  assign md_stall = bus.D_is_md && md_busy;
  assign stall    = hazard_rs || hazard_rt || md_stall;

  assign bus.stall     = stall;
  assign bus.PC_en     = !stall;
  assign bus.D_en      = !stall;
  assign bus.E_flush   = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
